// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the up/down counter: counting mode and direction encodings.
package updown_counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/updown_counter.sv
// Bounded up/down counter over 0..MAX_VALUE with wrap or saturate behaviour at the bounds.
// Define UPDOWN_COUNTER_ASSERT_EN to compile in concurrent protocol assertions.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrapped,
    output logic             saturated
);

    if (MAX_VALUE <= 0 || MAX_VALUE > (2 ** WIDTH) - 1) begin : gParamCheck
        $error("updown_counter: MAX_VALUE must lie in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             saturated_q, saturated_d;
    cnt_mode_e        mode_sel;

    assign mode_sel = cnt_mode_e'(mode);

    // Priority clear > load > en; reset is applied in the register block.
    always_comb begin
        count_d     = count_q;
        wrapped_d   = 1'b0;
        saturated_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (count_q == MaxVal) begin
                    if (mode_sel == CNT_SAT) begin
                        saturated_d = 1'b1;
                    end else begin
                        count_d   = '0;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    if (mode_sel == CNT_SAT) begin
                        saturated_d = 1'b1;
                    end else begin
                        count_d   = MaxVal;
                        wrapped_d = 1'b1;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            saturated_q <= saturated_d;
        end
    end

    assign count     = count_q;
    assign wrapped   = wrapped_q;
    assign saturated = saturated_q;
    assign at_max    = (count_q == MaxVal);
    assign at_zero   = (count_q == '0);

`ifdef UPDOWN_COUNTER_ASSERT_EN
    aCountInRange : assert property (@(posedge clk) disable iff (reset)
        count_q <= MaxVal);

    aPulsesExclusive : assert property (@(posedge clk) disable iff (reset)
        !(wrapped_q && saturated_q));

    // A second consecutive wrap needs en held high at a bound on the intervening edge.
    aWrapBackToBack : assert property (@(posedge clk) disable iff (reset)
        (wrapped_q && $past(wrapped_q)) |-> $past(en));
`else
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed scoreboard bench for updown_counter (WIDTH=4, MAX_VALUE=8).
module tb_updown_counter;

    localparam int WIDTH     = 4;
    localparam int MAX_VALUE = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             mode;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             wrapped;
    logic             saturated;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] cnt;
        logic             wrp;
        logic             sat;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    updown_counter #(
        .WIDTH    (WIDTH),
        .MAX_VALUE(MAX_VALUE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .at_max   (at_max),
        .at_zero  (at_zero),
        .wrapped  (wrapped),
        .saturated(saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmpBit(input string tag, input string field, input logic obs, input logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s.%s observed=%b expected=%b", tag, field, obs, expv);
        end
    endtask

    // Pops the oldest expectation and compares it with the outputs after the edge.
    task automatic checkOutput();
        exp_t e;
        compared++;
        assert (expQ.size() > 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected>0");
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compared++;
            assert (count === e.cnt) else begin
                mismatched++;
                $error("[TB] FAIL %s.count observed=%0d expected=%0d", e.tag, count, e.cnt);
            end
            cmpBit(e.tag, "wrapped",   wrapped,   e.wrp);
            cmpBit(e.tag, "saturated", saturated, e.sat);
            cmpBit(e.tag, "at_max",    at_max,    (e.cnt == 4'd8));
            cmpBit(e.tag, "at_zero",   at_zero,   (e.cnt == 4'd0));
        end
    endtask

    // Drives one cycle of inputs, records what the count must be after the edge, then checks it.
    task automatic applyStimulus(input string tag,
                                 input logic rst, input logic clr, input logic ld,
                                 input logic [WIDTH-1:0] ldv,
                                 input logic e, input logic u, input logic m,
                                 input logic [WIDTH-1:0] expCnt,
                                 input logic expWrp, input logic expSat);
        exp_t x;
        @(negedge clk);
        reset    = rst;
        clear    = clr;
        load     = ld;
        load_val = ldv;
        en       = e;
        up       = u;
        mode     = m;
        x.tag = tag;
        x.cnt = expCnt;
        x.wrp = expWrp;
        x.sat = expSat;
        expQ.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        en = 1'b0; up = 1'b1; mode = 1'b0;

        //                     tag          rst clr ld  ldv    en  up  mode  cnt   w     s
        applyStimulus("reset",      1, 0, 0, 4'd0,  0, 1, 0, 4'd0, 1'b0, 1'b0);

        // Wrap-mode count up 1..8, then wrap to 0 with a single pulse.
        for (int i = 1; i <= 8; i++)
            applyStimulus($sformatf("up_%0d", i), 0, 0, 0, 4'd0, 1, 1, 0, 4'(i), 1'b0, 1'b0);
        applyStimulus("wrap_up",    0, 0, 0, 4'd0,  1, 1, 0, 4'd0, 1'b1, 1'b0);
        applyStimulus("after_wrap", 0, 0, 0, 4'd0,  1, 1, 0, 4'd1, 1'b0, 1'b0);

        // Saturate at zero counting down.
        applyStimulus("clear",      0, 1, 0, 4'd0,  1, 1, 0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("sat_zero_%0d", i), 0, 0, 0, 4'd0, 1, 0, 1, 4'd0, 1'b0, 1'b1);

        // Load clamps to MAX_VALUE; clear beats load; load beats en.
        applyStimulus("load_13",    0, 0, 1, 4'd13, 0, 1, 0, 4'd8, 1'b0, 1'b0);
        applyStimulus("load_clear", 0, 1, 1, 4'd5,  0, 1, 0, 4'd0, 1'b0, 1'b0);
        applyStimulus("load_en",    0, 0, 1, 4'd4,  1, 1, 0, 4'd4, 1'b0, 1'b0);

        // Reset mid-count overrides en, counting resumes from 0.
        applyStimulus("load_5",     0, 0, 1, 4'd5,  0, 1, 0, 4'd5, 1'b0, 1'b0);
        applyStimulus("rst_mid",    1, 0, 0, 4'd0,  1, 1, 0, 4'd0, 1'b0, 1'b0);
        applyStimulus("resume_1",   0, 0, 0, 4'd0,  1, 1, 0, 4'd1, 1'b0, 1'b0);
        applyStimulus("resume_2",   0, 0, 0, 4'd0,  1, 1, 0, 4'd2, 1'b0, 1'b0);

        // Wrap down from 0 to 8, then switch to saturate at 8 counting up.
        applyStimulus("clear2",     0, 1, 0, 4'd0,  0, 1, 0, 4'd0, 1'b0, 1'b0);
        applyStimulus("wrap_down",  0, 0, 0, 4'd0,  1, 0, 0, 4'd8, 1'b1, 1'b0);
        applyStimulus("sat_max",    0, 0, 0, 4'd0,  1, 1, 1, 4'd8, 1'b0, 1'b1);
        applyStimulus("down_7",     0, 0, 0, 4'd0,  1, 0, 1, 4'd7, 1'b0, 1'b0);

        // Hold with en low.
        applyStimulus("load_3",     0, 0, 1, 4'd3,  0, 1, 0, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus($sformatf("hold_%0d", i), 0, 0, 0, 4'd0, 0, 1, 0, 4'd3, 1'b0, 1'b0);

        applyStimulus("down_2",     0, 0, 0, 4'd0,  1, 0, 0, 4'd2, 1'b0, 1'b0);
        applyStimulus("down_1",     0, 0, 0, 4'd0,  1, 0, 1, 4'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: count width in bits.
REQ-002 SHALL have parameter MAX_VALUE, default 8: terminal count; counting range is 0..MAX_VALUE inclusive.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 SHALL have port mode, input, 1 bit: 0 = wrap, 1 = saturate.
REQ-008 SHALL have port clear, input, 1 bit: synchronous clear to 0.
REQ-009 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 SHALL have port count, output, WIDTH bits: current count, registered.
REQ-012 SHALL have port at_max, output, 1 bit: high while count == MAX_VALUE.
REQ-013 SHALL have port at_zero, output, 1 bit: high while count == 0.
REQ-014 SHALL have port wrapped, output, 1 bit: registered one-cycle pulse on wrap-around.
REQ-015 SHALL have port saturated, output, 1 bit: registered one-cycle pulse when a count step is blocked at a bound in saturate mode.

Function
REQ-016 SHALL apply priority per edge: reset > clear > load > en; lower-priority requests in the same cycle are ignored.
REQ-017 SHALL, on clear, set count to 0 next cycle; wrapped and saturated SHALL be 0 that cycle.
REQ-018 SHALL, on load, set count to min(load_val, MAX_VALUE) next cycle; no pulse is generated.
REQ-019 SHALL, when en=1 and up=1 and count<MAX_VALUE, increment count by 1 (latency 1 cycle).
REQ-020 SHALL, when en=1 and up=0 and count>0, decrement count by 1.
REQ-021 SHALL, when en=1, up=1, count==MAX_VALUE and mode=0, set count to 0 and pulse wrapped for 1 cycle.
REQ-022 SHALL, when en=1, up=0, count==0 and mode=0, set count to MAX_VALUE and pulse wrapped for 1 cycle.
REQ-023 SHALL, in the bound cases of REQ-021/022 with mode=1, hold count and pulse saturated for 1 cycle.
REQ-024 SHALL hold count, with wrapped=saturated=0, when en=0 and no clear, load or reset is active.
REQ-025 SHALL derive at_max and at_zero combinationally from the count register, with no added latency.
REQ-026 SHALL, when mode changes mid-count, apply the new mode from the same edge; count is unaffected.
REQ-027 SHALL keep count in 0..MAX_VALUE at all times; arithmetic is WIDTH bits with no unintended overflow.

Reset
REQ-028 SHALL, on reset=1 at a rising clk edge, set count=0, wrapped=0 and saturated=0; at_zero=1 and at_max=0 follow.
REQ-029 SHALL, on reset asserted mid-count, override all other inputs; counting resumes from 0 on the first edge after deassertion.

Configuration
REQ-030 SHALL, when macro UPDOWN_COUNTER_ASSERT_EN is defined, compile in concurrent assertions clocked on clk and disabled during reset:
- count <= MAX_VALUE;
- wrapped and saturated never both high;
- wrapped is never high on two consecutive cycles unless en stays high at the same bound.
REQ-031 SHALL, without UPDOWN_COUNTER_ASSERT_EN, contain no assertion code and behave identically otherwise.
REQ-032 SHALL fail elaboration if MAX_VALUE == 0 or MAX_VALUE > 2**WIDTH-1.

Structure
REQ-033 SHALL place in shared package updown_counter_pkg: the enum cnt_mode_e (CNT_WRAP=0, CNT_SAT=1) and the direction constants DIR_DOWN=0 and DIR_UP=1.
REQ-034 SHALL be implemented as a single module; no sub-module is warranted.

Verification
REQ-035 SHALL cover: WIDTH=4, MAX_VALUE=8, mode=0, up=1, en=1 from reset -> count 0..8, then 0 with wrapped=1 for exactly 1 cycle; at_max=1 only at 8.
REQ-036 SHALL cover: mode=1, up=0, count=0, en=1 for 3 cycles -> count stays 0, saturated=1 on each blocked cycle, at_zero=1.
REQ-037 SHALL cover: load=1 with load_val=13 (MAX_VALUE=8) -> count=8 next cycle; load with clear in the same cycle -> count=0.
REQ-038 SHALL cover: reset asserted at count=5 while en=1 -> count=0 next edge; after release, counting resumes 1, 2, ...
REQ-039 SHALL cover: mode=0, up=0 at count=0 -> count=8 with wrapped pulse; then toggle to mode=1 at count=8 with up=1 -> count holds at 8 with saturated pulse.
REQ-040 SHALL cover: en=0 for 4 cycles at count=3 -> count holds at 3, no pulses.
